// File: rtl/spi_register_controller_if.sv
// Bundle of SPI-transceiver and register-bus signals around the SPI register controller.
// master: controller view; slave: transceiver/peripheral (or bench) view.
interface spi_register_controller_if #(
   parameter int unsigned AddrWidth = 3
) ();

   logic [7:0]           command;
   logic                 command_ready;
   logic [31:0]          word_received;
   logic                 word_rx_complete;
   logic                 cs;
   logic [31:0]          word_to_output;
   logic [AddrWidth-1:0] bus_addr;
   logic [31:0]          bus_wdata;
   logic                 bus_we;
   logic                 bus_req;
   logic                 bus_ack;
   logic [31:0]          bus_rdata;

   modport master (
      input  command,
      input  command_ready,
      input  word_received,
      input  word_rx_complete,
      input  cs,
      input  bus_ack,
      input  bus_rdata,
      output word_to_output,
      output bus_addr,
      output bus_wdata,
      output bus_we,
      output bus_req
   );

   modport slave (
      output command,
      output command_ready,
      output word_received,
      output word_rx_complete,
      output cs,
      output bus_ack,
      output bus_rdata,
      input  word_to_output,
      input  bus_addr,
      input  bus_wdata,
      input  bus_we,
      input  bus_req
   );

endinterface

// File: rtl/spi_register_controller.sv
// Command sequencer: decodes SPI command bytes into req/ack register-bus transactions.
// Define SPI_CTRL_AUTOINC_EN for burst mode (address auto-increments per word while cs is low).
module spi_register_controller #(
   parameter int unsigned NumRegs   = 8,
   parameter int unsigned AddrWidth = 3,
   parameter int unsigned Timeout   = 255
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   spi_register_controller_if.master ctrl_if,
   output logic                     busy_o,
   output logic [7:0]               error_count_o
);

   localparam int unsigned TmoWidth = $clog2(Timeout + 1);
   localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(Timeout - 1);
`ifdef SPI_CTRL_AUTOINC_EN
   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumRegs - 1);
`endif

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StReadReq,
      StWaitWord,
      StWriteReq,
      StHold,
      StError
   } state_e;

   state_e               state_q, state_d;
   logic                 write_q, write_d;
   logic                 inv_q, inv_d;
   logic                 rsvd_q, rsvd_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          word_q, word_d;
   logic [TmoWidth-1:0]  tmo_q, tmo_d;
   logic [7:0]           err_q, err_d;
   logic                 err_inc;
   logic                 cmd_bad;
   logic                 tmo_hit;
   logic                 bus_req, bus_we, busy;

   assign cmd_bad = rsvd_q | (32'(addr_q) >= NumRegs) | (write_q & inv_q);
   assign tmo_hit = (tmo_q == TmoLast);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= StIdle;
         write_q <= 1'b0;
         inv_q   <= 1'b0;
         rsvd_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         tmo_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         inv_q   <= inv_d;
         rsvd_q  <= rsvd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      inv_d   = inv_q;
      rsvd_d  = rsvd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      tmo_d   = '0;
      err_inc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ctrl_if.command_ready) begin
               write_d = ctrl_if.command[7];
               inv_d   = ctrl_if.command[6];
               rsvd_d  = |ctrl_if.command[5:AddrWidth];
               addr_d  = ctrl_if.command[AddrWidth-1:0];
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (ctrl_if.cs) begin
               state_d = StIdle;
            end else if (cmd_bad) begin
               state_d = StError;
            end else if (write_q) begin
               state_d = StWaitWord;
            end else begin
               state_d = StReadReq;
            end
         end
         StReadReq: begin
            tmo_d = tmo_q + 1'b1;
            // A completing ack takes priority over a simultaneous timeout.
            if (ctrl_if.bus_ack) begin
               word_d  = inv_q ? ~ctrl_if.bus_rdata : ctrl_if.bus_rdata;
               state_d = StHold;
            end else if (tmo_hit) begin
               word_d  = '1;
               err_inc = 1'b1;
               state_d = StHold;
            end
         end
         StWaitWord: begin
            if (ctrl_if.cs) begin
               state_d = StIdle;
            end else if (ctrl_if.word_rx_complete) begin
               wdata_d = ctrl_if.word_received;
               state_d = StWriteReq;
            end
         end
         StWriteReq: begin
            tmo_d = tmo_q + 1'b1;
            if (ctrl_if.bus_ack) begin
               state_d = StHold;
            end else if (tmo_hit) begin
               word_d  = '1;
               err_inc = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            if (ctrl_if.command_ready) begin
               err_inc = 1'b1;
            end
            if (ctrl_if.cs) begin
               state_d = StIdle;
`ifdef SPI_CTRL_AUTOINC_EN
            end else if (ctrl_if.word_rx_complete) begin
               addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
               if (write_q) begin
                  wdata_d = ctrl_if.word_received;
                  state_d = StWriteReq;
               end else begin
                  state_d = StReadReq;
               end
`endif
            end
         end
         StError: begin
            word_d  = 32'hDEAD_C0DE;
            err_inc = 1'b1;
            state_d = StHold;
         end
         default: state_d = StIdle;
      endcase
      err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
   end

   always_comb begin
      bus_req = (state_q == StReadReq) || (state_q == StWriteReq);
      bus_we  = (state_q == StWriteReq);
      busy    = (state_q != StIdle);
   end

   assign ctrl_if.bus_req        = bus_req;
   assign ctrl_if.bus_we         = bus_we;
   assign ctrl_if.bus_addr       = addr_q;
   assign ctrl_if.bus_wdata      = wdata_q;
   assign ctrl_if.word_to_output = word_q;
   assign busy_o                 = busy;
   assign error_count_o          = err_q;

endmodule

// File: tb/tb_spi_register_controller.sv
// Directed bench for spi_register_controller; honours SPI_CTRL_AUTOINC_EN for the burst case.
module tb_spi_register_controller;

   localparam int unsigned AddrWidth = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       busy;
   logic [7:0] error_count;

   int n_checks = 0;
   int n_errors = 0;
   int req_cyc  = 0;
   int n_wr     = 0;
   int base;
   int base_wr;
   int idx;
   int exp_wr;
   logic [AddrWidth-1:0] wr_addr [0:15];
   logic [31:0]          wr_data [0:15];

   spi_register_controller_if #(.AddrWidth(AddrWidth)) bus_if ();

   spi_register_controller #(
      .NumRegs   (8),
      .AddrWidth (AddrWidth),
      .Timeout   (255)
   ) dut (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .ctrl_if       (bus_if),
      .busy_o        (busy),
      .error_count_o (error_count)
   );

   always #5 clk = ~clk;

   // Bus monitor on the falling edge, where request/ack levels are settled.
   always @(negedge clk) begin
      if (bus_if.bus_req) req_cyc <= req_cyc + 1;
      if (bus_if.bus_req && bus_if.bus_ack && bus_if.bus_we) begin
         wr_addr[n_wr[3:0]] <= bus_if.bus_addr;
         wr_data[n_wr[3:0]] <= bus_if.bus_wdata;
         n_wr <= n_wr + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [7:0] cmd);
      bus_if.command       = cmd;
      bus_if.command_ready = 1'b1;
      tick(1);
      bus_if.command_ready = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      bus_if.word_received    = w;
      bus_if.word_rx_complete = 1'b1;
      tick(1);
      bus_if.word_rx_complete = 1'b0;
   endtask

   task automatic end_txn();
      bus_if.cs = 1'b1;
      tick(1);
      bus_if.cs = 1'b0;
      tick(1);
   endtask

   initial begin
      reset_n                 = 1'b0;
      bus_if.command          = '0;
      bus_if.command_ready    = 1'b0;
      bus_if.word_received    = '0;
      bus_if.word_rx_complete = 1'b0;
      bus_if.cs               = 1'b0;
      bus_if.bus_ack          = 1'b0;
      bus_if.bus_rdata        = '0;
      tick(2);
      check("rst_req", bus_if.bus_req, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_errcnt", error_count, 8'd0);
      check("rst_word", bus_if.word_to_output, 32'h0);
      reset_n = 1'b1;
      tick(1);

      // Read addr 3, ack in the fourth request cycle: data valid 5 edges after command_ready.
      base = req_cyc;
      send_cmd(8'h03);
      check("rd_busy", busy, 1'b1);
      tick(1);
      check("rd_req", bus_if.bus_req, 1'b1);
      check("rd_addr", bus_if.bus_addr, 3'd3);
      check("rd_we", bus_if.bus_we, 1'b0);
      tick(3);
      check("rd_word_early", bus_if.word_to_output, 32'h0);
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h1234_5678;
      tick(1);
      bus_if.bus_ack = 1'b0;
      check("rd_word", bus_if.word_to_output, 32'h1234_5678);
      check("rd_req_drop", bus_if.bus_req, 1'b0);
      check("rd_req_cycles", req_cyc - base, 4);
      tick(2);
      check("rd_hold_busy", busy, 1'b1);
      end_txn();
      check("rd_idle", busy, 1'b0);

      // Inverted read of addr 5.
      send_cmd(8'h45);
      tick(1);
      check("inv_addr", bus_if.bus_addr, 3'd5);
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h0000_00FF;
      tick(1);
      bus_if.bus_ack = 1'b0;
      check("inv_word", bus_if.word_to_output, 32'hFFFF_FF00);
      end_txn();

      // Write addr 2.
      base_wr = n_wr;
      send_cmd(8'h82);
      tick(1);
      check("wr_wait_noreq", bus_if.bus_req, 1'b0);
      send_word(32'hCAFE_F00D);
      check("wr_req", bus_if.bus_req, 1'b1);
      check("wr_we", bus_if.bus_we, 1'b1);
      check("wr_addr", bus_if.bus_addr, 3'd2);
      check("wr_wdata", bus_if.bus_wdata, 32'hCAFE_F00D);
      bus_if.bus_ack = 1'b1;
      tick(1);
      bus_if.bus_ack = 1'b0;
      check("wr_count", n_wr - base_wr, 1);
      check("wr_log_addr", wr_addr[base_wr & 15], 3'd2);
      check("wr_log_data", wr_data[base_wr & 15], 32'hCAFE_F00D);
      check("wr_word_keep", bus_if.word_to_output, 32'hFFFF_FF00);
      end_txn();

      // cs rises before the write word arrives: no bus activity.
      base = req_cyc;
      send_cmd(8'h81);
      tick(1);
      bus_if.cs = 1'b1;
      tick(1);
      check("abort_idle", busy, 1'b0);
      send_word(32'h1111_2222);
      bus_if.cs = 1'b0;
      tick(3);
      check("abort_noreq", req_cyc - base, 0);

      // Reserved bit set.
      send_cmd(8'h28);
      tick(2);
      check("rsvd_word", bus_if.word_to_output, 32'hDEAD_C0DE);
      check("rsvd_errcnt", error_count, 8'd1);
      end_txn();

      // Read that is never acked: request held exactly 255 cycles.
      base = req_cyc;
      send_cmd(8'h01);
      tick(1);
      for (int i = 0; i < 400 && bus_if.bus_req; i++) tick(1);
      check("tmo_req_drop", bus_if.bus_req, 1'b0);
      check("tmo_req_cycles", req_cyc - base, 255);
      check("tmo_word", bus_if.word_to_output, 32'hFFFF_FFFF);
      check("tmo_errcnt", error_count, 8'd2);
      end_txn();

      // Ack in the final timeout cycle wins.
      send_cmd(8'h02);
      tick(1);
      tick(254);
      check("tmo_edge_req", bus_if.bus_req, 1'b1);
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'hA5A5_0F0F;
      tick(1);
      bus_if.bus_ack = 1'b0;
      check("tmo_edge_word", bus_if.word_to_output, 32'hA5A5_0F0F);
      check("tmo_edge_errcnt", error_count, 8'd2);

      // Command while holding is an error; state stays in HOLD.
      send_cmd(8'h03);
      check("hold_cmd_errcnt", error_count, 8'd3);
      check("hold_cmd_busy", busy, 1'b1);
      check("hold_cmd_noreq", bus_if.bus_req, 1'b0);
      end_txn();

      // Write with invert is illegal.
      send_cmd(8'hC1);
      tick(2);
      check("wrinv_word", bus_if.word_to_output, 32'hDEAD_C0DE);
      check("wrinv_errcnt", error_count, 8'd4);
      end_txn();

      for (int i = 0; i < 300; i++) begin
         send_cmd(8'h28);
         tick(2);
         end_txn();
      end
      check("sat_errcnt", error_count, 8'd255);

      // Write burst starting at the last address.
      base_wr = n_wr;
      send_cmd(8'h87);
      tick(1);
      for (int k = 0; k < 3; k++) begin
         send_word(32'h1000_0000 + k);
         if (bus_if.bus_req) begin
            bus_if.bus_ack = 1'b1;
            tick(1);
            bus_if.bus_ack = 1'b0;
         end
         tick(1);
      end
`ifdef SPI_CTRL_AUTOINC_EN
      exp_wr = 3;
`else
      exp_wr = 1;
`endif
      check("burst_count", n_wr - base_wr, exp_wr);
      check("burst_addr0", wr_addr[base_wr & 15], 3'd7);
      check("burst_data0", wr_data[base_wr & 15], 32'h1000_0000);
`ifdef SPI_CTRL_AUTOINC_EN
      idx = (base_wr + 1) & 15;
      check("burst_addr1", wr_addr[idx], 3'd0);
      check("burst_data1", wr_data[idx], 32'h1000_0001);
      idx = (base_wr + 2) & 15;
      check("burst_addr2", wr_addr[idx], 3'd1);
      check("burst_data2", wr_data[idx], 32'h1000_0002);
`endif
      check("burst_word_keep", bus_if.word_to_output, 32'hDEAD_C0DE);
      end_txn();

      // Asynchronous reset in the middle of a write request.
      send_cmd(8'h81);
      tick(1);
      send_word(32'h5555_AAAA);
      check("arst_pre_req", bus_if.bus_req, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_req", bus_if.bus_req, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_errcnt", error_count, 8'd0);
      check("arst_word", bus_if.word_to_output, 32'h0);
      tick(1);
      reset_n = 1'b1;
      tick(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
